adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Capture sequencer that sits directly upstream of the ADC sample FIFO in the ADC test design, in the ADC clock domain. On a start command it discards a settling window, then writes exactly `num_samples` ADC codes, optionally decimated, into the FIFO write port, replacing the free-running write enable. It also reports busy/done/overflow status and tracks min/max codes over the capture for the host status wires.

## Interface
- `PRECISION`, 10, ADC code width
- `COUNT_WIDTH`, 12, width of sample count and request
- `SETTLE_CYCLES`, 4, raw `clk` cycles discarded after start before the first capture slot
- `clk`  in  1  ADC clock; FIFO `wr_clk` is driven from the same net
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; begins a capture when idle
- `abort`  in  1  level; terminates any capture
- `num_samples`  in  COUNT_WIDTH  samples to capture; latched on accepted `start`
- `decim`  in  8  capture one slot every `decim+1` cycles; latched on `start`
- `adc_code_in`  in  PRECISION  raw ADC code, valid every cycle
- `fifo_full`  in  1  FIFO full flag, write domain
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_din`  out  PRECISION  FIFO write data
- `busy`  out  1  high in SETTLE or CAPTURE
- `done`  out  1  one-cycle pulse when capture completes normally
- `overflow`  out  1  sticky; a slot was dropped because FIFO was full
- `sample_count`  out  COUNT_WIDTH  capture slots taken in the current or last capture
- `code_min`, `code_max`  out  PRECISION each  extremes over slots taken

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: on `start` with `abort` low, latch `num_samples` and `decim`. Clear `sample_count`, `overflow`, and the decimation counter. Set `code_min` to all-ones and `code_max` to 0. Go to SETTLE, or to DONE if `num_samples`==0.
- SETTLE: count `SETTLE_CYCLES` cycles, then go to CAPTURE. No writes occur. `SETTLE_CYCLES`=0 goes to CAPTURE the next cycle.
- CAPTURE: a slot occurs on the first CAPTURE cycle, then every `decim+1` cycles.
  - Each slot registers `adc_code_in`, increments `sample_count`, and updates min/max.
  - Each slot raises the write request for exactly one cycle.
  - After the slot that brings `sample_count` to the latched count, go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE. Status outputs hold until the next accepted `start`.
- `start` outside IDLE is ignored.
- `abort` in any state: next state is IDLE. Any pending write is cancelled, no `done` is produced, and status holds its current values.
- `abort` has priority over `start` in the same cycle.
- Full handling:
  - `fifo_wr_en` = write request AND NOT `fifo_full`, combinational.
  - A request seen with `fifo_full` high is dropped and sets `overflow`.
  - A dropped slot still counts in `sample_count`, so the capture always terminates.
- Counters never wrap: the maximum request is 2^COUNT_WIDTH−1.
- Min/max compare is unsigned.

## Timing
- Reset values:
  - state IDLE
  - `fifo_wr_en`, `busy`, `done`, `overflow` = 0
  - `fifo_din`, `sample_count`, `code_max` = 0
  - `code_min` = all-ones
- `start` at cycle 0 gives `busy` high at cycle 1. SETTLE occupies cycles 1..`SETTLE_CYCLES`.
- A slot at cycle t samples `adc_code_in` at edge t. `fifo_din` and `fifo_wr_en` are valid during cycle t+1. Latency is 1 cycle.
- `done` asserts the cycle after the final write cycle. `busy` drops in that same cycle.
- With `decim`=0, writes are back-to-back for `num_samples` cycles.
- `rst` mid-capture restores reset values at the next edge. Any partially asserted write ends at that edge.

## Structure
- Shared package `adc_test_pkg`: `PRECISION`, `COUNT_WIDTH`, and the state enum (IDLE/SETTLE/CAPTURE/DONE).
- One sub-module, `adc_minmax`: clear input, update strobe, code input, and registered min/max outputs.
- Top level instantiates this block between the ADC pins and `fifo_adc`. Host control (start, abort, num_samples, decim) must be synchronized into `clk` outside this block.

## Test plan
- Reset, then `start` with `num_samples`=8, `decim`=0, ramp input 0..: exactly 8 writes of consecutive codes, first at cycle `SETTLE_CYCLES`+2. `done` pulses once, `sample_count`=8, `overflow`=0.
- `num_samples`=4, `decim`=2: writes spaced 3 cycles apart carrying every third ramp value. `done` follows the 4th write.
- `fifo_full` held high for slots 2–3 of 6: 4 writes, `overflow`=1, `sample_count`=6, `done` still pulses.
- `abort` during CAPTURE after 3 writes: no further writes, no `done`, `busy` low the next cycle, `sample_count`=3.
- `num_samples`=0: no writes and `done` one cycle after `start`. A second `start` while busy is ignored.
- Input codes {0x155, 0x3FF, 0x000, 0x200}: `code_min`=0x000, `code_max`=0x3FF. Reset mid-capture returns all outputs to their reset values.

Source files
------------

// File: rtl/adc_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_test_pkg
// Purpose  : Shared widths and capture-sequencer state encoding for the ADC
//            test design.
// Revision : 1.0  initial release
// ============================================================================
package adc_test_pkg;

    localparam int PRECISION   = 10;
    localparam int COUNT_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/adc_minmax.sv
`default_nettype none
// ============================================================================
// Module   : adc_minmax
// Purpose  : Running unsigned minimum/maximum of strobed ADC codes.
// Revision : 1.0  initial release
// ============================================================================
module adc_minmax #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             update_i,
    input  logic [WIDTH-1:0] code_i,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
);

    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;

    // Min starts at all-ones so the first strobed code always replaces it.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_min <= '1;
            r_max <= '0;
        end else if (update_i) begin
            if (code_i < r_min) r_min <= code_i;
            if (code_i > r_max) r_max <= code_i;
        end
    end

    assign min_o = r_min;
    assign max_o = r_max;

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_ctrl
// Purpose  : Start/settle/capture sequencer driving the ADC sample FIFO write
//            port, with busy/done/overflow status and min/max tracking.
// Revision : 1.0  initial release
// ============================================================================
module adc_capture_ctrl
    import adc_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] num_samples,
    input  logic [7:0]             decim,
    input  logic [PRECISION-1:0]   adc_code_in,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [PRECISION-1:0]   fifo_din,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic [PRECISION-1:0]   code_min,
    output logic [PRECISION-1:0]   code_max
);

    localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_settle_w-1:0] c_settle_last =
        c_settle_w'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_e                 r_state;
    logic [COUNT_WIDTH-1:0] r_target;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [7:0]             r_decim;
    logic [7:0]             r_decim_cnt;
    logic [c_settle_w-1:0]  r_settle_cnt;
    logic [PRECISION-1:0]   r_din;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;

    logic w_accept;
    logic w_slot;
    logic w_last;

    assign w_accept = (r_state == IDLE) && start && !abort;
    assign w_slot   = (r_state == CAPTURE) && (r_decim_cnt == 8'd0) && !abort;
    assign w_last   = (r_count == r_target - COUNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_target     <= '0;
            r_count      <= '0;
            r_decim      <= '0;
            r_decim_cnt  <= '0;
            r_settle_cnt <= '0;
            r_din        <= '0;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            if (r_req && fifo_full && !abort) r_overflow <= 1'b1;

            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_target     <= num_samples;
                            r_decim      <= decim;
                            r_count      <= '0;
                            r_overflow   <= 1'b0;
                            r_decim_cnt  <= '0;
                            r_settle_cnt <= '0;
                            if (num_samples == '0) begin
                                // Empty request completes immediately.
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_busy  <= 1'b1;
                                r_state <= (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (r_settle_cnt == c_settle_last) r_state <= CAPTURE;
                        else r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                    CAPTURE: begin
                        r_decim_cnt <= (r_decim_cnt == r_decim) ? 8'd0 : r_decim_cnt + 8'd1;
                        if (w_slot) begin
                            r_din   <= adc_code_in;
                            r_req   <= 1'b1;
                            r_count <= r_count + COUNT_WIDTH'(1);
                            if (w_last) r_state <= DONE;
                        end
                    end
                    DONE: begin
                        // The final write is still on the port here; done follows it.
                        r_done  <= r_req;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    adc_minmax #(
        .WIDTH (PRECISION)
    ) u_minmax (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_accept),
        .update_i (w_slot),
        .code_i   (adc_code_in),
        .min_o    (code_min),
        .max_o    (code_max)
    );

    assign fifo_wr_en   = r_req & ~fifo_full;
    assign fifo_din     = r_din;
    assign busy         = r_busy;
    assign done         = r_done;
    assign overflow     = r_overflow;
    assign sample_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_ctrl
// Purpose  : Scoreboard bench for adc_capture_ctrl (write stream and done).
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_capture_ctrl;

    localparam int P  = adc_test_pkg::PRECISION;
    localparam int CW = adc_test_pkg::COUNT_WIDTH;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_samples;
    logic [7:0]    decim;
    logic [P-1:0]  adc_code_in;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [P-1:0]  fifo_din;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] sample_count;
    logic [P-1:0]  code_min;
    logic [P-1:0]  code_max;

    adc_capture_ctrl #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_samples  (num_samples),
        .decim        (decim),
        .adc_code_in  (adc_code_in),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .sample_count (sample_count),
        .code_min     (code_min),
        .code_max     (code_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [P-1:0] code;
    } wexp_t;

    wexp_t        wq[$];
    int           dq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    int           t0     = 0;
    int           full_lo = 1000;
    int           full_hi = 1000;
    bit           tab_en = 1'b0;
    bit           mon_en = 1'b0;
    logic [P-1:0] tab[16];

    function automatic logic [P-1:0] in_at(int idx);
        if (tab_en && idx >= 0 && idx < 16) return tab[idx];
        return P'(idx);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge, away from sampling.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        adc_code_in = in_at(cyc - t0);
        fifo_full   = ((cyc - t0) >= full_lo) && ((cyc - t0) <= full_hi);
    endtask

    task automatic run_to(int idx);
        for (int i = 0; i < 64 && (cyc - t0) < idx; i++) step();
    endtask

    task automatic do_start(int n, int d);
        step();
        t0          = cyc;
        adc_code_in = in_at(0);
        fifo_full   = 1'b0;
        start       = 1'b1;
        num_samples = CW'(n);
        decim       = 8'(d);
        step();
        start = 1'b0;
    endtask

    // Slot k is taken at t0+S+1+k*(d+1); its write appears one cycle later.
    task automatic push_caps(int n, int d, int nslots, int drop_lo, int drop_hi, bit with_done);
        for (int k = 0; k < nslots; k++) begin
            int s;
            wexp_t e;
            s = t0 + S + 1 + k * (d + 1);
            e.cyc  = s + 1;
            e.code = in_at(s - t0);
            if (k < drop_lo || k > drop_hi) wq.push_back(e);
        end
        if (with_done) dq.push_back(t0 + S + 1 + (n - 1) * (d + 1) + 2);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (fifo_wr_en) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got data 0x%0h at cycle %0d, expected no write",
                             fifo_din, cyc);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    if (e.cyc != cyc || e.code != fifo_din) begin
                        errors++;
                        $display("FAIL write: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                                 fifo_din, cyc, e.code, e.cyc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    int ed;
                    ed = dq.pop_front();
                    if (ed != cyc) begin
                        errors++;
                        $display("FAIL done_cycle: got cycle %0d expected cycle %0d", cyc, ed);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_samples = '0; decim = '0;
        adc_code_in = '0; fifo_full = 1'b0;
        for (int i = 0; i < 16; i++) tab[i] = 10'h100;
        step(); step();
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_min", code_min, 10'h3FF);
        chk("rst_max", code_max, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Back-to-back capture of 8 ramp codes.
        do_start(8, 0);
        push_caps(8, 0, 8, 99, 99, 1'b1);
        chk("t1_busy_rise", busy, 1);
        run_to(13);
        chk("t1_busy_last_write", busy, 1);
        step();
        chk("t1_busy_fall", busy, 0);
        run_to(20);
        chk("t1_count", sample_count, 8);
        chk("t1_overflow", overflow, 0);
        chk("t1_min", code_min, 5);
        chk("t1_max", code_max, 12);

        // Decimate by 3, with stray starts while busy that must be ignored.
        do_start(4, 2);
        push_caps(4, 2, 4, 99, 99, 1'b1);
        start = 1'b1; num_samples = CW'(2); decim = 8'd0;
        step();
        start = 1'b0;
        run_to(7);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(22);
        chk("t2_count", sample_count, 4);
        chk("t2_busy", busy, 0);

        // FIFO full for slots 2-3 of 6.
        full_lo = 7; full_hi = 8;
        do_start(6, 0);
        push_caps(6, 0, 6, 1, 2, 1'b1);
        run_to(20);
        full_lo = 1000; full_hi = 1000;
        chk("t3_count", sample_count, 6);
        chk("t3_overflow", overflow, 1);

        // Abort after the third write.
        do_start(8, 0);
        push_caps(8, 0, 3, 99, 99, 1'b0);
        run_to(8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        run_to(20);
        chk("t4_count", sample_count, 3);
        chk("t4_overflow", overflow, 0);

        // Empty request completes one cycle after start with no writes.
        do_start(0, 0);
        dq.push_back(t0 + 1);
        chk("t5_busy", busy, 0);
        run_to(6);
        chk("t5_count", sample_count, 0);

        // Min/max over a fixed code set.
        tab[5] = 10'h155; tab[6] = 10'h3FF; tab[7] = 10'h000; tab[8] = 10'h200;
        tab_en = 1'b1;
        do_start(4, 0);
        push_caps(4, 0, 4, 99, 99, 1'b1);
        run_to(14);
        tab_en = 1'b0;
        chk("t6_min", code_min, 10'h000);
        chk("t6_max", code_max, 10'h3FF);
        chk("t6_count", sample_count, 4);

        // Reset in the middle of a capture.
        do_start(8, 0);
        push_caps(8, 0, 3, 99, 99, 1'b0);
        run_to(8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_wr_en", fifo_wr_en, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_din", fifo_din, 0);
        chk("t7_count", sample_count, 0);
        chk("t7_min", code_min, 10'h3FF);
        chk("t7_max", code_max, 0);
        run_to(20);
        chk("t7_idle_busy", busy, 0);

        chk("writes_outstanding", wq.size(), 0);
        chk("done_outstanding", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
